// File: rtl/calc_pkg.sv
// Shared constants for the 4-bit calculator datapath.
// Holds op_code encodings and the ALU operation selector.
package calc_pkg;

    localparam logic [2:0] OP_LOAD_A  = 3'b001;
    localparam logic [2:0] OP_LOAD_B  = 3'b011;
    localparam logic [2:0] OP_COMPUTE = 3'b101;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_DIV = 2'b11
    } alu_op_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU: ADD/SUB/MUL/DIV on two 4-bit operands.
// Produces an 8-bit result plus negative and divide-by-zero flags.
module calc_alu
    import calc_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  alu_op_e    op_i,
    output logic [7:0] res_o,
    output logic       neg_o,
    output logic       dz_o
);

    logic [4:0] sum;
    logic [7:0] prod;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign prod = {4'b0, a_i} * {4'b0, b_i};

    always_comb begin
        res_o = 8'h00;
        neg_o = 1'b0;
        dz_o  = 1'b0;
        unique case (op_i)
            ALU_ADD: res_o = {3'b0, sum};
            ALU_SUB: begin
                // SUB reports a magnitude and flags the sign separately
                if (a_i >= b_i) begin
                    res_o = {4'b0, a_i - b_i};
                end else begin
                    res_o = {4'b0, b_i - a_i};
                    neg_o = 1'b1;
                end
            end
            ALU_MUL: res_o = prod;
            ALU_DIV: begin
                if (b_i == 4'd0) begin
                    dz_o = 1'b1;
                end else begin
                    res_o = {a_i % b_i, a_i / b_i};
                end
            end
            default: res_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/calculator_datapath_unit.sv
// Calculator datapath: operand registers, op_code decode and
// registered ALU result with status flags.
module calculator_datapath_unit
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] data_in,
    input  logic [2:0] op_code,
    input  logic [1:0] compute_op,
    output logic [7:0] result,
    output logic       done,
    output logic       negative,
    output logic       div_by_zero
);

    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [7:0] res_q, res_d;
    logic       done_q, done_d;
    logic       neg_q, neg_d;
    logic       dz_q, dz_d;

    logic [7:0] alu_res;
    logic       alu_neg;
    logic       alu_dz;

    calc_alu u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (alu_op_e'(compute_op)),
        .res_o (alu_res),
        .neg_o (alu_neg),
        .dz_o  (alu_dz)
    );

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        neg_d  = neg_q;
        dz_d   = dz_q;
        done_d = 1'b0;
        unique case (op_code)
            OP_LOAD_A: a_d = data_in;
            OP_LOAD_B: b_d = data_in;
            OP_COMPUTE: begin
                res_d  = alu_res;
                neg_d  = alu_neg;
                dz_d   = alu_dz;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= 4'd0;
            b_q    <= 4'd0;
            res_q  <= 8'h00;
            done_q <= 1'b0;
            neg_q  <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            done_q <= done_d;
            neg_q  <= neg_d;
            dz_q   <= dz_d;
        end
    end

    assign result      = res_q;
    assign done        = done_q;
    assign negative    = neg_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_calculator_datapath_unit.sv
// Table-driven bench for calculator_datapath_unit with an
// expected-result queue filled at drive time, drained after the edge.
module tb_calculator_datapath_unit;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] data_in;
    logic [2:0] op_code;
    logic [1:0] compute_op;
    logic [7:0] result;
    logic       done;
    logic       negative;
    logic       div_by_zero;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] d;
        logic [1:0] cop;
        logic [7:0] res;
        logic       neg;
        logic       dz;
        logic       dn;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       neg;
        logic       dz;
        logic       dn;
    } exp_t;

    exp_t  sb[$];
    vec_t  tbl[25];

    calculator_datapath_unit dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .op_code     (op_code),
        .compute_op  (compute_op),
        .result      (result),
        .done        (done),
        .negative    (negative),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (result !== e.res || negative !== e.neg ||
            div_by_zero !== e.dz || done !== e.dn) begin
            fails++;
            $display("FAIL %s: got res=%h neg=%b dz=%b done=%b, want res=%h neg=%b dz=%b done=%b",
                     name, result, negative, div_by_zero, done,
                     e.res, e.neg, e.dz, e.dn);
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] op,
                        input logic [3:0] d, input logic [1:0] cop,
                        input exp_t e, input string name);
        @(negedge clk);
        reset      = rst;
        op_code    = op;
        data_in    = d;
        compute_op = cop;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic n,
                                input logic z, input logic dn);
        exp_t e;
        e.res = r;
        e.neg = n;
        e.dz  = z;
        e.dn  = dn;
        return e;
    endfunction

    localparam logic [2:0] NOP0 = 3'b000;
    localparam logic [2:0] NOP7 = 3'b111;
    localparam logic [2:0] NOP2 = 3'b010;

    initial begin
        tbl[0]  = '{OP_LOAD_A,  4'd7,  ALU_ADD, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{OP_LOAD_B,  4'd3,  ALU_ADD, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{OP_COMPUTE, 4'd0,  ALU_ADD, 8'h0A, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{OP_COMPUTE, 4'd0,  ALU_SUB, 8'h04, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{OP_LOAD_A,  4'd3,  ALU_ADD, 8'h04, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{OP_LOAD_B,  4'd7,  ALU_ADD, 8'h04, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{OP_COMPUTE, 4'd0,  ALU_SUB, 8'h04, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{OP_COMPUTE, 4'd0,  ALU_MUL, 8'h15, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{OP_COMPUTE, 4'd0,  ALU_DIV, 8'h30, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{OP_LOAD_A,  4'd15, ALU_ADD, 8'h30, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{OP_LOAD_B,  4'd4,  ALU_ADD, 8'h30, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{OP_COMPUTE, 4'd0,  ALU_DIV, 8'h33, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{OP_LOAD_B,  4'd0,  ALU_ADD, 8'h33, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{OP_COMPUTE, 4'd0,  ALU_DIV, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{OP_COMPUTE, 4'd0,  ALU_ADD, 8'h0F, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{NOP0,       4'd9,  ALU_ADD, 8'h0F, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{OP_LOAD_B,  4'd15, ALU_ADD, 8'h0F, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{OP_COMPUTE, 4'd0,  ALU_ADD, 8'h1E, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{OP_COMPUTE, 4'd0,  ALU_MUL, 8'hE1, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{OP_LOAD_A,  4'd0,  ALU_ADD, 8'hE1, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{OP_COMPUTE, 4'd0,  ALU_SUB, 8'h0F, 1'b1, 1'b0, 1'b1};
        tbl[21] = '{NOP7,       4'd5,  ALU_ADD, 8'h0F, 1'b1, 1'b0, 1'b0};
        tbl[22] = '{OP_COMPUTE, 4'd0,  ALU_SUB, 8'h0F, 1'b1, 1'b0, 1'b1};
        tbl[23] = '{NOP2,       4'd9,  ALU_ADD, 8'h0F, 1'b1, 1'b0, 1'b0};
        tbl[24] = '{OP_COMPUTE, 4'd0,  ALU_ADD, 8'h0F, 1'b0, 1'b0, 1'b1};

        reset      = 1'b1;
        op_code    = NOP0;
        data_in    = 4'd0;
        compute_op = ALU_ADD;

        step(1'b1, NOP0, 4'd0, ALU_ADD, mk(8'h00, 1'b0, 1'b0, 1'b0), "reset0");
        step(1'b1, NOP0, 4'd0, ALU_ADD, mk(8'h00, 1'b0, 1'b0, 1'b0), "reset1");

        for (int i = 0; i < 25; i++) begin
            step(1'b0, tbl[i].op, tbl[i].d, tbl[i].cop,
                 mk(tbl[i].res, tbl[i].neg, tbl[i].dz, tbl[i].dn),
                 $sformatf("vec%0d", i));
        end

        // Reset while COMPUTE is active and flags are set
        step(1'b0, OP_COMPUTE, 4'd0, ALU_SUB, mk(8'h0F, 1'b1, 1'b0, 1'b1), "pre_rst");
        step(1'b1, OP_COMPUTE, 4'd0, ALU_SUB, mk(8'h00, 1'b0, 1'b0, 1'b0), "rst_in_cmp");
        step(1'b0, OP_COMPUTE, 4'd0, ALU_MUL, mk(8'h00, 1'b0, 1'b0, 1'b1), "cmp_after_rst");

        // Reset beats a concurrent load
        step(1'b0, OP_LOAD_A, 4'd9, ALU_ADD, mk(8'h00, 1'b0, 1'b0, 1'b0), "ldA9");
        step(1'b1, OP_LOAD_B, 4'd6, ALU_ADD, mk(8'h00, 1'b0, 1'b0, 1'b0), "rst_vs_ld");
        step(1'b0, OP_COMPUTE, 4'd0, ALU_ADD, mk(8'h00, 1'b0, 1'b0, 1'b1), "add_zero");

        // Divide-by-zero flag cleared by a following DIV with B != 0
        step(1'b0, OP_COMPUTE, 4'd0, ALU_DIV, mk(8'h00, 1'b0, 1'b1, 1'b1), "dz_set");
        step(1'b0, OP_LOAD_A, 4'd13, ALU_DIV, mk(8'h00, 1'b0, 1'b1, 1'b0), "ldA13");
        step(1'b0, OP_LOAD_B, 4'd5, ALU_DIV, mk(8'h00, 1'b0, 1'b1, 1'b0), "ldB5");
        step(1'b0, OP_COMPUTE, 4'd0, ALU_DIV, mk(8'h32, 1'b0, 1'b0, 1'b1), "div13_5");
        step(1'b0, OP_COMPUTE, 4'd0, ALU_SUB, mk(8'h08, 1'b0, 1'b0, 1'b1), "sub13_5");

        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_drain: got %0d left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
